// File: rtl/vx_writeback_commit_if.sv
// rtl/vx_writeback_commit_if.sv - execution-unit result bundle and writeback stream
interface vx_writeback_commit_if #(
   parameter int NUM_INPUTS  = 4,
   parameter int ISSUE_WIS_W = 2,
   parameter int NR_BITS     = 6,
   parameter int NUM_THREADS = 4,
   parameter int XLEN        = 32,
   parameter int PC_BITS     = 30,
   parameter int UUID_WIDTH  = 1
) ();
   localparam int SEL_W = $clog2(NUM_INPUTS);

   // result packets from the execution units, flattened per input
   logic [NUM_INPUTS-1:0]                  in_valid;
   logic [NUM_INPUTS-1:0]                  in_ready;
   logic [NUM_INPUTS*ISSUE_WIS_W-1:0]      in_wis;
   logic [NUM_INPUTS*NR_BITS-1:0]          in_rd;
   logic [NUM_INPUTS*NUM_THREADS-1:0]      in_tmask;
   logic [NUM_INPUTS*PC_BITS-1:0]          in_pc;
   logic [NUM_INPUTS*UUID_WIDTH-1:0]       in_uuid;
   logic [NUM_INPUTS-1:0]                  in_wb;
   logic [NUM_INPUTS-1:0]                  in_eop;
   logic [NUM_INPUTS*NUM_THREADS*XLEN-1:0] in_data;

   // merged writeback stream; the sink always accepts
   logic                                   wb_valid;
   logic [ISSUE_WIS_W-1:0]                 wb_wis;
   logic [NR_BITS-1:0]                     wb_rd;
   logic [NUM_THREADS-1:0]                 wb_tmask;
   logic [PC_BITS-1:0]                     wb_pc;
   logic [UUID_WIDTH-1:0]                  wb_uuid;
   logic                                   wb_eop;
   logic [NUM_THREADS*XLEN-1:0]            wb_data;
   logic [SEL_W-1:0]                       wb_sel;

   modport master (
      output in_valid, in_wis, in_rd, in_tmask, in_pc, in_uuid, in_wb, in_eop, in_data,
      input  in_ready,
      input  wb_valid, wb_wis, wb_rd, wb_tmask, wb_pc, wb_uuid, wb_eop, wb_data, wb_sel
   );

   modport slave (
      input  in_valid, in_wis, in_rd, in_tmask, in_pc, in_uuid, in_wb, in_eop, in_data,
      output in_ready,
      output wb_valid, wb_wis, wb_rd, wb_tmask, wb_pc, wb_uuid, wb_eop, wb_data, wb_sel
   );
endinterface

// File: rtl/vx_writeback_commit.sv
// rtl/vx_writeback_commit.sv - round-robin commit arbiter with multi-packet lock and perf counters
module vx_writeback_commit #(
   parameter int NUM_INPUTS    = 4,
   parameter int ISSUE_WIS_W   = 2,
   parameter int NR_BITS       = 6,
   parameter int NUM_THREADS   = 4,
   parameter int XLEN          = 32,
   parameter int PC_BITS       = 30,
   parameter int UUID_WIDTH    = 1,
   parameter int PERF_CTR_BITS = 44
) (
   input  logic                     clk,
   input  logic                     reset,
   vx_writeback_commit_if.slave     bus,
   output logic [PERF_CTR_BITS-1:0] perf_commits,
   output logic [PERF_CTR_BITS-1:0] perf_conflicts
);
   localparam int SEL_W = $clog2(NUM_INPUTS);
   localparam int CNT_W = $clog2(NUM_INPUTS + 1);
   localparam int DW    = NUM_THREADS * XLEN;

   logic [SEL_W-1:0]         rr_ptr_q, rr_ptr_d;
   logic                     lock_q, lock_d;
   logic [SEL_W-1:0]         lock_idx_q, lock_idx_d;
   logic                     wb_valid_q, wb_valid_d;
   logic [ISSUE_WIS_W-1:0]   wb_wis_q, wb_wis_d;
   logic [NR_BITS-1:0]       wb_rd_q, wb_rd_d;
   logic [NUM_THREADS-1:0]   wb_tmask_q, wb_tmask_d;
   logic [PC_BITS-1:0]       wb_pc_q, wb_pc_d;
   logic [UUID_WIDTH-1:0]    wb_uuid_q, wb_uuid_d;
   logic                     wb_eop_q, wb_eop_d;
   logic [DW-1:0]            wb_data_q, wb_data_d;
   logic [SEL_W-1:0]         wb_sel_q, wb_sel_d;
   logic [PERF_CTR_BITS-1:0] commits_q, commits_d;
   logic [PERF_CTR_BITS-1:0] conflicts_q, conflicts_d;

   logic [NUM_INPUTS-1:0]    cand;
   logic                     grant_valid;
   logic [SEL_W-1:0]         grant;
   logic [NUM_INPUTS-1:0]    grant_oh;
   logic [NUM_INPUTS-1:0]    ready;
   logic [CNT_W-1:0]         cand_cnt;
   logic [CNT_W-1:0]         eop_cnt;

   // pick one writeback candidate: the locked input, else first at/after rr_ptr
   always_comb begin
      int idx;
      cand        = bus.in_valid & bus.in_wb;
      grant_valid = 1'b0;
      grant       = '0;
      idx         = 0;
      if (lock_q) begin
         grant_valid = cand[lock_idx_q];
         grant       = lock_idx_q;
      end else begin
         // descending scan so the nearest input to rr_ptr is the last to assign
         for (int k = NUM_INPUTS - 1; k >= 0; k--) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= NUM_INPUTS) idx = idx - NUM_INPUTS;
            if (cand[SEL_W'(idx)]) begin
               grant_valid = 1'b1;
               grant       = SEL_W'(idx);
            end
         end
      end
   end

   // accept non-writeback packets freely, writeback packets only when granted
   always_comb begin
      grant_oh = '0;
      if (grant_valid) grant_oh[grant] = 1'b1;
      ready = reset ? (bus.in_valid & (~bus.in_wb | grant_oh)) : '0;
      cand_cnt = '0;
      eop_cnt  = '0;
      for (int i = 0; i < NUM_INPUTS; i++) begin
         cand_cnt = cand_cnt + CNT_W'(cand[i]);
         eop_cnt  = eop_cnt + CNT_W'(ready[i] & bus.in_eop[i]);
      end
   end

   // next state: lock/pointer update, output register load, perf counters
   always_comb begin
      int gi;
      gi          = int'(grant);
      rr_ptr_d    = rr_ptr_q;
      lock_d      = lock_q;
      lock_idx_d  = lock_idx_q;
      wb_valid_d  = grant_valid;
      wb_wis_d    = wb_wis_q;
      wb_rd_d     = wb_rd_q;
      wb_tmask_d  = wb_tmask_q;
      wb_pc_d     = wb_pc_q;
      wb_uuid_d   = wb_uuid_q;
      wb_eop_d    = wb_eop_q;
      wb_data_d   = wb_data_q;
      wb_sel_d    = wb_sel_q;
      commits_d   = commits_q + PERF_CTR_BITS'(eop_cnt);
      conflicts_d = conflicts_q + PERF_CTR_BITS'(cand_cnt >= CNT_W'(2));
      if (grant_valid) begin
         if (bus.in_eop[grant]) begin
            lock_d   = 1'b0;
            rr_ptr_d = (gi == NUM_INPUTS - 1) ? '0 : grant + SEL_W'(1);
         end else begin
            lock_d     = 1'b1;
            lock_idx_d = grant;
         end
         wb_wis_d   = bus.in_wis[gi*ISSUE_WIS_W +: ISSUE_WIS_W];
         wb_rd_d    = bus.in_rd[gi*NR_BITS +: NR_BITS];
         wb_tmask_d = bus.in_tmask[gi*NUM_THREADS +: NUM_THREADS];
         wb_pc_d    = bus.in_pc[gi*PC_BITS +: PC_BITS];
         wb_uuid_d  = bus.in_uuid[gi*UUID_WIDTH +: UUID_WIDTH];
         wb_eop_d   = bus.in_eop[grant];
         wb_data_d  = bus.in_data[gi*DW +: DW];
         wb_sel_d   = grant;
      end
   end

   // state registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!reset) begin
         rr_ptr_q    <= '0;
         lock_q      <= 1'b0;
         lock_idx_q  <= '0;
         wb_valid_q  <= 1'b0;
         wb_wis_q    <= '0;
         wb_rd_q     <= '0;
         wb_tmask_q  <= '0;
         wb_pc_q     <= '0;
         wb_uuid_q   <= '0;
         wb_eop_q    <= 1'b0;
         wb_data_q   <= '0;
         wb_sel_q    <= '0;
         commits_q   <= '0;
         conflicts_q <= '0;
      end else begin
         rr_ptr_q    <= rr_ptr_d;
         lock_q      <= lock_d;
         lock_idx_q  <= lock_idx_d;
         wb_valid_q  <= wb_valid_d;
         wb_wis_q    <= wb_wis_d;
         wb_rd_q     <= wb_rd_d;
         wb_tmask_q  <= wb_tmask_d;
         wb_pc_q     <= wb_pc_d;
         wb_uuid_q   <= wb_uuid_d;
         wb_eop_q    <= wb_eop_d;
         wb_data_q   <= wb_data_d;
         wb_sel_q    <= wb_sel_d;
         commits_q   <= commits_d;
         conflicts_q <= conflicts_d;
      end
   end

   assign bus.in_ready   = ready;
   assign bus.wb_valid   = wb_valid_q;
   assign bus.wb_wis     = wb_wis_q;
   assign bus.wb_rd      = wb_rd_q;
   assign bus.wb_tmask   = wb_tmask_q;
   assign bus.wb_pc      = wb_pc_q;
   assign bus.wb_uuid    = wb_uuid_q;
   assign bus.wb_eop     = wb_eop_q;
   assign bus.wb_data    = wb_data_q;
   assign bus.wb_sel     = wb_sel_q;
   assign perf_commits   = commits_q;
   assign perf_conflicts = conflicts_q;
endmodule

// File: tb/tb_vx_writeback_commit.sv
// tb/tb_vx_writeback_commit.sv - directed scoreboard bench for vx_writeback_commit
module tb_vx_writeback_commit;
   localparam int N   = 4;
   localparam int WW  = 2;
   localparam int NR  = 6;
   localparam int NT  = 4;
   localparam int XL  = 32;
   localparam int PCB = 30;
   localparam int UW  = 1;
   localparam int PB  = 44;

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   vx_writeback_commit_if #(.NUM_INPUTS(N), .ISSUE_WIS_W(WW), .NR_BITS(NR), .NUM_THREADS(NT),
                            .XLEN(XL), .PC_BITS(PCB), .UUID_WIDTH(UW)) bus ();
   logic [PB-1:0] perf_commits;
   logic [PB-1:0] perf_conflicts;

   vx_writeback_commit #(.NUM_INPUTS(N), .ISSUE_WIS_W(WW), .NR_BITS(NR), .NUM_THREADS(NT),
                         .XLEN(XL), .PC_BITS(PCB), .UUID_WIDTH(UW), .PERF_CTR_BITS(PB)) dut (
      .clk            (clk),
      .reset          (reset),
      .bus            (bus.slave),
      .perf_commits   (perf_commits),
      .perf_conflicts (perf_conflicts)
   );

   typedef struct packed {
      logic [1:0]       sel;
      logic [NR-1:0]    rd;
      logic [WW-1:0]    wis;
      logic [NT-1:0]    tmask;
      logic [PCB-1:0]   pc;
      logic [UW-1:0]    uuid;
      logic             eop;
      logic [NT*XL-1:0] data;
   } pkt_t;

   pkt_t exp_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   logic [N-1:0] s_valid;
   logic [N-1:0] s_wb;
   logic [N-1:0] s_eop;
   logic [7:0]   s_tag [N];

   // packet contents are a fixed function of (input, tag, eop); tag 8'h45 gives rd=5, wis=1
   function automatic pkt_t mk(input int i, input logic [7:0] tag, input logic eop);
      pkt_t p;
      p.sel   = 2'(i);
      p.rd    = tag[5:0];
      p.wis   = tag[7:6];
      p.tmask = tag[3:0] ^ 4'(i);
      p.pc    = {20'h0, 2'(i), tag};
      p.uuid  = tag[0];
      p.eop   = eop;
      for (int l = 0; l < NT; l++) p.data[l*XL +: XL] = {tag, 8'(i), 8'(l), 8'h5A};
      return p;
   endfunction

   task automatic apply();
      pkt_t p;
      bus.in_valid = s_valid;
      bus.in_wb    = s_wb;
      bus.in_eop   = s_eop;
      for (int i = 0; i < N; i++) begin
         p = mk(i, s_tag[i], s_eop[i]);
         bus.in_wis[i*WW +: WW]          = p.wis;
         bus.in_rd[i*NR +: NR]           = p.rd;
         bus.in_tmask[i*NT +: NT]        = p.tmask;
         bus.in_pc[i*PCB +: PCB]         = p.pc;
         bus.in_uuid[i*UW +: UW]         = p.uuid;
         bus.in_data[i*NT*XL +: NT*XL]   = p.data;
      end
   endtask

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic drive();
      apply();
      @(negedge clk);
   endtask

   task automatic adv();
      @(posedge clk);
      #1;
   endtask

   task automatic set_all(input logic [N-1:0] v, input logic [N-1:0] w, input logic [N-1:0] e,
                          input logic [7:0] tag_base);
      s_valid = v;
      s_wb    = w;
      s_eop   = e;
      for (int i = 0; i < N; i++) s_tag[i] = tag_base + 8'(i);
   endtask

   // monitor: every writeback packet must match the oldest expected packet
   always @(negedge clk) begin
      pkt_t got;
      pkt_t exp;
      if (bus.wb_valid === 1'b1) begin
         n_tests++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL wb_unexpected: got sel %0d rd %0h with nothing expected", bus.wb_sel, bus.wb_rd);
         end else begin
            exp = exp_q.pop_front();
            got = {bus.wb_sel, bus.wb_rd, bus.wb_wis, bus.wb_tmask, bus.wb_pc, bus.wb_uuid,
                   bus.wb_eop, bus.wb_data};
            if (got !== exp) begin
               n_fail++;
               $display("FAIL wb_pkt: got %h expected %h", got, exp);
            end
         end
      end
   end

   initial begin
      // reset held two cycles with all inputs presenting writeback packets
      reset = 1'b0;
      set_all(4'b1111, 4'b1111, 4'b1111, 8'h10);
      drive(); chk("rst_ready0", 64'(bus.in_ready), 64'h0); adv();
      drive(); chk("rst_ready1", 64'(bus.in_ready), 64'h0);
      chk("rst_wb_valid", 64'(bus.wb_valid), 64'h0);
      chk("rst_commits", 64'(perf_commits), 64'h0);
      chk("rst_conflicts", 64'(perf_conflicts), 64'h0);
      adv();

      // release with only input 2 presenting rd=5 wis=1
      reset = 1'b1;
      set_all(4'b0100, 4'b0100, 4'b0100, 8'h00);
      s_tag[2] = 8'h45;
      exp_q.push_back(mk(2, 8'h45, 1'b1));
      drive(); chk("rel_ready", 64'(bus.in_ready), 64'h4); adv();
      set_all(4'b0000, 4'b0000, 4'b0000, 8'h00);
      drive(); chk("rel_commits", 64'(perf_commits), 64'd1); adv();

      // round-robin: rr_ptr is 3 after the grant to input 2
      for (int c = 0; c < 8; c++) begin
         int g;
         g = (3 + c) % N;
         set_all(4'b1111, 4'b1111, 4'b1111, 8'(8'h20 + 8'(c*4)));
         exp_q.push_back(mk(g, s_tag[g], 1'b1));
         drive(); chk("rr_ready", 64'(bus.in_ready), 64'(1 << g)); adv();
      end
      set_all(4'b0000, 4'b0000, 4'b0000, 8'h00);
      drive();
      chk("rr_commits", 64'(perf_commits), 64'd9);
      chk("rr_conflicts", 64'(perf_conflicts), 64'd8);
      adv();

      // lock: move rr_ptr to 1 with a lone grant to input 0
      set_all(4'b0001, 4'b0001, 4'b0001, 8'h60);
      exp_q.push_back(mk(0, s_tag[0], 1'b1));
      drive(); chk("lk_pre_ready", 64'(bus.in_ready), 64'h1); adv();
      set_all(4'b0011, 4'b0011, 4'b0001, 8'h64);
      exp_q.push_back(mk(1, s_tag[1], 1'b0));
      drive(); chk("lk_p0_ready", 64'(bus.in_ready), 64'h2); adv();
      set_all(4'b0011, 4'b0011, 4'b0001, 8'h68);
      exp_q.push_back(mk(1, s_tag[1], 1'b0));
      drive(); chk("lk_p1_ready", 64'(bus.in_ready), 64'h2); adv();
      // locked input idle: input 0 waits, a non-writeback packet still passes
      set_all(4'b1001, 4'b0001, 4'b1001, 8'h6C);
      drive(); chk("lk_idle_ready", 64'(bus.in_ready), 64'h8); adv();
      set_all(4'b0011, 4'b0011, 4'b0011, 8'h70);
      exp_q.push_back(mk(1, s_tag[1], 1'b1));
      drive(); chk("lk_p2_ready", 64'(bus.in_ready), 64'h2); adv();
      // rr_ptr must now be 2: with 0,1,2 pending, 2 wins, then 0, then 1
      set_all(4'b0111, 4'b0111, 4'b0111, 8'h74);
      exp_q.push_back(mk(2, s_tag[2], 1'b1));
      drive(); chk("lk_ptr2_ready", 64'(bus.in_ready), 64'h4); adv();
      set_all(4'b0111, 4'b0111, 4'b0111, 8'h78);
      exp_q.push_back(mk(0, s_tag[0], 1'b1));
      drive(); chk("lk_ptr3_ready", 64'(bus.in_ready), 64'h1); adv();
      set_all(4'b0111, 4'b0111, 4'b0111, 8'h7C);
      exp_q.push_back(mk(1, s_tag[1], 1'b1));
      drive(); chk("lk_ptr1_ready", 64'(bus.in_ready), 64'h2); adv();

      // non-writeback bypass on inputs 0 and 3 alongside a grant to input 1
      set_all(4'b1011, 4'b0010, 4'b1011, 8'h80);
      exp_q.push_back(mk(1, s_tag[1], 1'b1));
      drive(); chk("byp_ready", 64'(bus.in_ready), 64'hB); adv();
      set_all(4'b0000, 4'b0000, 4'b0000, 8'h00);
      drive();
      chk("byp_commits", 64'(perf_commits), 64'd18);
      chk("byp_conflicts", 64'(perf_conflicts), 64'd14);
      adv();

      // reset while input 2 holds the lock
      set_all(4'b0100, 4'b0100, 4'b0000, 8'h90);
      exp_q.push_back(mk(2, s_tag[2], 1'b0));
      drive(); chk("ml_start_ready", 64'(bus.in_ready), 64'h4); adv();
      reset = 1'b0;
      set_all(4'b0101, 4'b0101, 4'b0101, 8'h94);
      drive(); chk("ml_rst_ready", 64'(bus.in_ready), 64'h0); adv();
      reset = 1'b1;
      set_all(4'b0101, 4'b0101, 4'b0101, 8'h98);
      exp_q.push_back(mk(0, s_tag[0], 1'b1));
      drive();
      chk("ml_rel_ready", 64'(bus.in_ready), 64'h1);
      chk("ml_commits", 64'(perf_commits), 64'h0);
      chk("ml_conflicts", 64'(perf_conflicts), 64'h0);
      adv();
      set_all(4'b0101, 4'b0101, 4'b0101, 8'h9C);
      exp_q.push_back(mk(2, s_tag[2], 1'b1));
      drive(); chk("ml_next_ready", 64'(bus.in_ready), 64'h4); adv();

      // drain and confirm every expected packet appeared
      set_all(4'b0000, 4'b0000, 4'b0000, 8'h00);
      drive(); adv();
      drive(); adv();
      chk("sb_empty", 64'(exp_q.size()), 64'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
